// File: rtl/pwm_pkg.sv
// Shared types and widths for the PWM duty path.
package pwm_pkg;

    // Duty and period-counter width; must match the PWM counter.
    localparam int unsigned DUTY_W = 11;

    typedef logic [DUTY_W-1:0] duty_t;

    // Ramp status reported alongside the registered duty.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } ramp_state_t;

endpackage : pwm_pkg

// File: rtl/period_cnt.sv
// Free-running PWM period counter with last-clock-of-period decode.
// Shared with the PWM block so both stay aligned off the same reset.
module period_cnt
    import pwm_pkg::*;
#(
    parameter int unsigned W = DUTY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] cnt,
    output logic         period_end
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: plain increment, wraps from all-ones to zero.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign period_end = &cnt_q;

endmodule : period_cnt

// File: rtl/duty_slew.sv
// Duty target buffer and slew limiter feeding the PWM duty input.
// Targets arrive over valid/ready, wait in a one-deep pending slot and
// are applied only on the last clock of a PWM period, optionally limited
// to SLEW_STEP counts per period.
module duty_slew
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_W     = pwm_pkg::DUTY_W,
    parameter int unsigned SLEW_STEP  = 8,
    parameter int unsigned RESET_DUTY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] tgt_duty,
    input  logic              tgt_vld,
    output logic              tgt_rdy,
    input  logic              ramp_en,
    output logic [DUTY_W-1:0] duty,
    output logic              period_end,
    output logic              settled,
    output logic [1:0]        state
);

    localparam logic [DUTY_W:0]   STEP_X  = (DUTY_W+1)'(SLEW_STEP);
    localparam logic [DUTY_W-1:0] STEP    = DUTY_W'(SLEW_STEP);
    localparam logic [DUTY_W-1:0] RST_VAL = DUTY_W'(RESET_DUTY);

    // Counter value is only needed by the PWM block itself.
    logic [DUTY_W-1:0] cnt_unused;

    period_cnt #(
        .W (DUTY_W)
    ) u_period_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt        (cnt_unused),
        .period_end (period_end)
    );

    logic [DUTY_W-1:0] duty_q,     duty_d;
    logic [DUTY_W-1:0] tgt_q,      tgt_d;
    logic [DUTY_W-1:0] pend_q,     pend_d;
    logic              pend_vld_q, pend_vld_d;
    ramp_state_t       state_q,    state_d;

    logic [DUTY_W-1:0] eff_tgt;
    logic [DUTY_W-1:0] step_duty;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   dn_limit;
    logic              take;

    // Slew step toward the effective target. Both directions compare in
    // DUTY_W+1 bits; the downward case tests duty <= E+STEP instead of
    // subtracting, so no intermediate value can go below zero.
    always_comb begin
        eff_tgt   = pend_vld_q ? pend_q : tgt_q;
        up_sum    = {1'b0, duty_q} + STEP_X;
        dn_limit  = {1'b0, eff_tgt} + STEP_X;
        step_duty = eff_tgt;
        if (ramp_en) begin
            if (eff_tgt > duty_q) begin
                step_duty = (up_sum >= {1'b0, eff_tgt}) ? eff_tgt : up_sum[DUTY_W-1:0];
            end else if (eff_tgt < duty_q) begin
                step_duty = ({1'b0, duty_q} <= dn_limit) ? eff_tgt : (duty_q - STEP);
            end
        end
    end

    // Next-state: boundary update of duty/target/state, then handshake capture.
    always_comb begin
        duty_d     = duty_q;
        tgt_d      = tgt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        state_d    = state_q;
        take       = tgt_vld && !pend_vld_q;

        if (period_end) begin
            tgt_d      = eff_tgt;
            duty_d     = step_duty;
            pend_vld_d = 1'b0;
            if (step_duty < eff_tgt) begin
                state_d = RAMP_UP;
            end else if (step_duty > eff_tgt) begin
                state_d = RAMP_DN;
            end else begin
                state_d = IDLE;
            end
        end

        // A capture on the boundary clock lands in pend for the next period.
        if (take) begin
            pend_d     = tgt_duty;
            pend_vld_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q     <= RST_VAL;
            tgt_q      <= RST_VAL;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            state_q    <= IDLE;
        end else begin
            duty_q     <= duty_d;
            tgt_q      <= tgt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            state_q    <= state_d;
        end
    end

    assign tgt_rdy = !pend_vld_q;
    assign duty    = duty_q;
    assign settled = (duty_q == tgt_q) && !pend_vld_q;
    assign state   = state_q;

endmodule : duty_slew

// File: tb/tb_duty_slew.sv
// Bench for duty_slew: boundary results are queued as stimulus is driven
// and compared by a monitor after every period_end edge.
module tb_duty_slew;
    import pwm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [10:0] tgt_duty;
    logic        tgt_vld;
    logic        tgt_rdy;
    logic        ramp_en;
    logic [10:0] duty;
    logic        period_end;
    logic        settled;
    logic [1:0]  state;

    duty_slew #(
        .DUTY_W     (11),
        .SLEW_STEP  (8),
        .RESET_DUTY (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tgt_duty   (tgt_duty),
        .tgt_vld    (tgt_vld),
        .tgt_rdy    (tgt_rdy),
        .ramp_en    (ramp_en),
        .duty       (duty),
        .period_end (period_end),
        .settled    (settled),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] duty;
        logic [1:0]  st;
        logic        settled;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic pe_s  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_bnd(input logic [10:0] d, input logic [1:0] st, input logic s);
        exp_t e;
        e.duty    = d;
        e.st      = st;
        e.settled = s;
        sb.push_back(e);
    endtask

    // period_end sampled mid-cycle marks the following rising edge as a boundary.
    always @(negedge clk) pe_s = period_end;

    // Scoreboard monitor: compare DUT outputs just after each boundary edge.
    always @(posedge clk) begin
        if (pe_s && rst_n) begin
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("bnd_duty",    32'(duty),    32'(e.duty));
                check("bnd_state",   32'(state),   32'(e.st));
                check("bnd_settled", 32'(settled), 32'(e.settled));
            end
        end
    end

    task automatic wait_boundary();
        int n;
        n = 0;
        @(negedge clk);
        while (!period_end && n < 2100) begin
            @(negedge clk);
            n++;
        end
        check("bnd_timeout", 32'(n < 2100), 32'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic push_tgt(input logic [10:0] v);
        int n;
        n = 0;
        @(negedge clk);
        tgt_duty = v;
        tgt_vld  = 1'b1;
        while (!tgt_rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("push_timeout", 32'(n < 5000), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        tgt_vld = 1'b0;
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        tgt_vld  = 1'b0;
        tgt_duty = '0;
        ramp_en  = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_duty",    32'(duty),       32'h0);
        check("rst_rdy",     32'(tgt_rdy),    32'h1);
        check("rst_settled", 32'(settled),    32'h1);
        check("rst_state",   32'(state),      32'(IDLE));
        check("rst_pe",      32'(period_end), 32'h0);

        // First period_end after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        expect_bnd(11'h000, IDLE, 1'b1);
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (period_end) break;
        end
        check("first_pe", 32'(n), 32'd2047);
        wait_boundary();

        // Direct jump with ramp disabled.
        ramp_en = 1'b0;
        repeat (10) @(negedge clk);
        expect_bnd(11'h0FF, IDLE, 1'b1);
        push_tgt(11'h0FF);
        check("hold_duty", 32'(duty),    32'h0);
        check("rdy_busy",  32'(tgt_rdy), 32'h0);
        wait_boundary();
        check("rdy_after",     32'(tgt_rdy), 32'h1);
        check("settled_after", 32'(settled), 32'h1);

        // Back to zero, then ramp up by 8 per period.
        expect_bnd(11'h000, IDLE, 1'b1);
        push_tgt(11'h000);
        wait_boundary();
        ramp_en = 1'b1;
        expect_bnd(11'h008, RAMP_UP, 1'b0);
        expect_bnd(11'h010, RAMP_UP, 1'b0);
        expect_bnd(11'h018, RAMP_UP, 1'b0);
        expect_bnd(11'h020, IDLE,    1'b1);
        push_tgt(11'h020);
        repeat (4) wait_boundary();

        // Clamp at the top and at zero.
        ramp_en = 1'b0;
        expect_bnd(11'h7FC, IDLE, 1'b1);
        push_tgt(11'h7FC);
        wait_boundary();
        ramp_en = 1'b1;
        expect_bnd(11'h7FF, IDLE, 1'b1);
        push_tgt(11'h7FF);
        wait_boundary();
        ramp_en = 1'b0;
        expect_bnd(11'h004, IDLE, 1'b1);
        push_tgt(11'h004);
        wait_boundary();
        ramp_en = 1'b1;
        expect_bnd(11'h000, IDLE, 1'b1);
        push_tgt(11'h000);
        wait_boundary();

        // Back-pressure: B held while A is pending.
        ramp_en = 1'b0;
        expect_bnd(11'h100, IDLE, 1'b1);
        push_tgt(11'h100);
        tgt_duty = 11'h200;
        tgt_vld  = 1'b1;
        #1;
        check("b_blocked", 32'(tgt_rdy), 32'h0);
        wait_boundary();
        check("b_rdy", 32'(tgt_rdy), 32'h1);
        @(posedge clk);
        #1;
        check("b_taken", 32'(tgt_rdy), 32'h0);
        @(negedge clk);
        tgt_vld = 1'b0;
        expect_bnd(11'h200, IDLE, 1'b1);
        wait_boundary();

        // Push on the period_end clock: held over to the next boundary.
        expect_bnd(11'h200, IDLE, 1'b0);
        n = 0;
        @(negedge clk);
        while (!period_end && n < 2100) begin
            @(negedge clk);
            n++;
        end
        check("pe_wait", 32'(n < 2100), 32'd1);
        tgt_duty = 11'h300;
        tgt_vld  = 1'b1;
        @(posedge clk);
        #2;
        check("pe_push_pend", 32'(tgt_rdy), 32'h0);
        check("pe_push_duty", 32'(duty),    32'h200);
        @(negedge clk);
        tgt_vld = 1'b0;
        expect_bnd(11'h300, IDLE, 1'b1);
        wait_boundary();

        // Reset mid-ramp with a pending target.
        ramp_en = 1'b0;
        expect_bnd(11'h010, IDLE, 1'b1);
        push_tgt(11'h010);
        wait_boundary();
        ramp_en = 1'b1;
        expect_bnd(11'h018, RAMP_UP, 1'b0);
        push_tgt(11'h020);
        wait_boundary();
        push_tgt(11'h050);
        check("mid_pend", 32'(tgt_rdy), 32'h0);
        check("mid_duty", 32'(duty),    32'h018);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_duty",    32'(duty),    32'h0);
        check("arst_rdy",     32'(tgt_rdy), 32'h1);
        check("arst_settled", 32'(settled), 32'h1);
        check("arst_state",   32'(state),   32'(IDLE));
        check("sb_drain",     32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_duty_slew
